// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Purpose  : SPI mode-0 flash target answering WREN/WRDI/RDSR/READ/PP/SE/RDID
//            from a small internal byte array. All SPI pins are oversampled
//            by i_clk; i_spi_clk is treated as data, never as a clock.
// Ports    : i_clk, i_rst      - system clock, synchronous active-high reset
//            i_spi_clk         - SPI clock from master (CPOL=0, asynchronous)
//            i_spi_cs          - chip select, active low
//            i_spi_mosi        - master-out data
//            o_spi_miso        - target-out data (1 when not driving data)
//            o_busy, o_wel     - debug copies of status bits 0 and 1
// Params   : ADDR_W (array depth 2^ADDR_W), PROG_CYCLES, JEDEC_ID
// Options  : SPI_RESP_NOR_AND_EN - program ANDs new data into the old byte
//            (NOR semantics); undefined, program overwrites the byte.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
  parameter int          ADDR_W      = 8,
  parameter int          PROG_CYCLES = 64,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4018
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_spi_clk,
  input  logic i_spi_cs,
  input  logic i_spi_mosi,
  output logic o_spi_miso,
  output logic o_busy,
  output logic o_wel
);

  localparam int         DEPTH   = 1 << ADDR_W;
  localparam int         PCNT_W  = $clog2(PROG_CYCLES + 1);
  localparam logic [7:0] OP_WREN = 8'h06;
  localparam logic [7:0] OP_WRDI = 8'h04;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_SE   = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CMD     = 4'd1,
    ST_ADDR    = 4'd2,
    ST_STAT    = 4'd3,
    ST_ID      = 4'd4,
    ST_RD_DATA = 4'd5,
    ST_WR_DATA = 4'd6,
    ST_TAIL    = 4'd7,
    ST_IGNORE  = 4'd8
  } state_t;

  // --------------------------------------------------------------------------
  // Pin synchronizers; third stage of SCLK/CS only serves edge detection.
  // --------------------------------------------------------------------------
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic cs_s1_q, cs_s2_q, cs_s3_q;
  logic mosi_s1_q, mosi_s2_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_s3_q <= 1'b0;
      cs_s1_q   <= 1'b1;
      cs_s2_q   <= 1'b1;
      cs_s3_q   <= 1'b1;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
    end else begin
      sclk_s1_q <= i_spi_clk;
      sclk_s2_q <= sclk_s1_q;
      sclk_s3_q <= sclk_s2_q;
      cs_s1_q   <= i_spi_cs;
      cs_s2_q   <= cs_s1_q;
      cs_s3_q   <= cs_s2_q;
      mosi_s1_q <= i_spi_mosi;
      mosi_s2_q <= mosi_s1_q;
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  assign sclk_rise = sclk_s2_q & ~sclk_s3_q;
  assign sclk_fall = ~sclk_s2_q & sclk_s3_q;
  assign cs_rise   = cs_s2_q & ~cs_s3_q;
  assign cs_fall   = ~cs_s2_q & cs_s3_q;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [7:0]          op_q, op_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;     // bit position within byte
  logic [5:0]          tot_cnt_q, tot_cnt_d;     // rises since CS fall, saturating
  logic [6:0]          shift_q, shift_d;         // previous 7 MOSI bits
  logic [ADDR_W-2:0]   addr_q, addr_d;           // low address bits seen so far
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [7:0]          out_q, out_d;             // byte currently shifting out
  logic [2:0]          out_cnt_q, out_cnt_d;
  logic [1:0]          id_idx_q, id_idx_d;
  logic                wrote_q, wrote_d;         // at least one PP byte committed
  logic                miso_q, miso_d;
  logic                wel_q, wel_d;
  logic                busy_q, busy_d;
  logic                sweep_q, sweep_d;
  logic [ADDR_W-1:0]   sweep_ptr_q, sweep_ptr_d;
  logic [PCNT_W-1:0]   prog_cnt_q, prog_cnt_d;

  logic [7:0]          mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [7:0]          mem_wdata;

  logic [7:0]          byte_in;
  logic [ADDR_W-1:0]   new_addr;
  logic [ADDR_W-1:0]   rd_idx;
  logic [7:0]          rd_data;
  logic [7:0]          status;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    bit_cnt_d   = bit_cnt_q;
    tot_cnt_d   = tot_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    ptr_d       = ptr_q;
    out_d       = out_q;
    out_cnt_d   = out_cnt_q;
    id_idx_d    = id_idx_q;
    wrote_d     = wrote_q;
    miso_d      = miso_q;
    wel_d       = wel_q;
    sweep_d     = sweep_q;
    sweep_ptr_d = sweep_ptr_q;
    prog_cnt_d  = prog_cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = sweep_ptr_q;
    mem_wdata   = 8'hFF;

    byte_in  = {shift_q, mosi_s2_q};
    new_addr = {addr_q, mosi_s2_q};
    // Address phase needs the byte at the incoming address; otherwise the
    // pointer is the only read source (read prefetch and NOR merge).
    rd_idx   = (state_q == ST_ADDR) ? new_addr : ptr_q;
    rd_data  = mem_q[rd_idx];
    status   = {6'b0, wel_q, busy_q};

    // Background: erase/reset sweep and program busy countdown.
    if (sweep_q) begin
      mem_we      = 1'b1;
      sweep_ptr_d = sweep_ptr_q + 1'b1;
      if (sweep_ptr_q == {ADDR_W{1'b1}}) begin
        sweep_d = 1'b0;
        wel_d   = 1'b0;
      end
    end
    if (prog_cnt_q != '0) begin
      prog_cnt_d = prog_cnt_q - 1'b1;
      if (prog_cnt_q == PCNT_W'(1)) wel_d = 1'b0;
    end

    if (cs_rise) begin
      state_d = ST_IDLE;
      miso_d  = 1'b1;
      case (state_q)
        ST_TAIL: begin
          if (op_q == OP_WREN && tot_cnt_q == 6'd8) wel_d = 1'b1;
          if (op_q == OP_WRDI && tot_cnt_q == 6'd8) wel_d = 1'b0;
          if (op_q == OP_SE && tot_cnt_q == 6'd32 && wel_q) begin
            sweep_d     = 1'b1;
            sweep_ptr_d = '0;
          end
        end
        ST_WR_DATA: begin
          if (wrote_q) prog_cnt_d = PCNT_W'(PROG_CYCLES);
        end
        default: ;
      endcase
    end else if (cs_fall) begin
      state_d   = ST_CMD;
      bit_cnt_d = 3'd0;
      tot_cnt_d = 6'd0;
      wrote_d   = 1'b0;
      miso_d    = 1'b1;
    end else if (sclk_rise && state_q != ST_IDLE) begin
      shift_d   = byte_in[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (tot_cnt_q != 6'h3F) tot_cnt_d = tot_cnt_q + 6'd1;
      case (state_q)
        ST_CMD: begin
          if (bit_cnt_q == 3'd7) begin
            op_d      = byte_in;
            out_cnt_d = 3'd0;
            if (busy_q && byte_in != OP_RDSR) begin
              state_d = ST_IGNORE;
            end else begin
              case (byte_in)
                OP_RDSR: begin
                  state_d = ST_STAT;
                  out_d   = status;
                end
                OP_RDID: begin
                  state_d  = ST_ID;
                  out_d    = JEDEC_ID[23:16];
                  id_idx_d = 2'd1;
                end
                OP_WREN, OP_WRDI: state_d = ST_TAIL;
                OP_READ, OP_SE:   state_d = ST_ADDR;
                OP_PP:            state_d = wel_q ? ST_ADDR : ST_IGNORE;
                default:          state_d = ST_IGNORE;
              endcase
            end
          end
        end
        ST_ADDR: begin
          addr_d = new_addr[ADDR_W-2:0];
          if (tot_cnt_q == 6'd31) begin
            case (op_q)
              OP_READ: begin
                state_d   = ST_RD_DATA;
                out_d     = rd_data;
                ptr_d     = new_addr + 1'b1;
                out_cnt_d = 3'd0;
              end
              OP_PP: begin
                state_d = ST_WR_DATA;
                ptr_d   = new_addr;
              end
              default: state_d = ST_TAIL;
            endcase
          end
        end
        ST_WR_DATA: begin
          if (bit_cnt_q == 3'd7) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
`ifdef SPI_RESP_NOR_AND_EN
            mem_wdata = rd_data & byte_in;
`else
            mem_wdata = byte_in;
`endif
            ptr_d     = ptr_q + 1'b1;
            wrote_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (sclk_fall && (state_q inside {ST_STAT, ST_ID, ST_RD_DATA})) begin
      miso_d    = out_q[~out_cnt_q];
      out_cnt_d = out_cnt_q + 3'd1;
      // Last bit of the byte goes out now; stage the next byte so its MSB is
      // ready for the following falling edge.
      if (out_cnt_q == 3'd7) begin
        case (state_q)
          ST_STAT: out_d = status;
          ST_ID: begin
            case (id_idx_q)
              2'd1:    begin out_d = JEDEC_ID[15:8]; id_idx_d = 2'd2; end
              2'd2:    begin out_d = JEDEC_ID[7:0];  id_idx_d = 2'd3; end
              default: out_d = 8'hFF;
            endcase
          end
          default: begin
            out_d = rd_data;
            ptr_d = ptr_q + 1'b1;
          end
        endcase
      end
    end

    busy_d = sweep_d | (prog_cnt_d != '0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 8'h00;
      bit_cnt_q   <= 3'd0;
      tot_cnt_q   <= 6'd0;
      shift_q     <= 7'd0;
      addr_q      <= '0;
      ptr_q       <= '0;
      out_q       <= 8'hFF;
      out_cnt_q   <= 3'd0;
      id_idx_q    <= 2'd0;
      wrote_q     <= 1'b0;
      miso_q      <= 1'b1;
      wel_q       <= 1'b0;
      busy_q      <= 1'b1;
      sweep_q     <= 1'b1;
      sweep_ptr_q <= '0;
      prog_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      bit_cnt_q   <= bit_cnt_d;
      tot_cnt_q   <= tot_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      out_cnt_q   <= out_cnt_d;
      id_idx_q    <= id_idx_d;
      wrote_q     <= wrote_d;
      miso_q      <= miso_d;
      wel_q       <= wel_d;
      busy_q      <= busy_d;
      sweep_q     <= sweep_d;
      sweep_ptr_q <= sweep_ptr_d;
      prog_cnt_q  <= prog_cnt_d;
    end
  end

  // Array has no reset; the sweep clears it. A write due on a reset cycle is
  // dropped so an interrupted program leaves no trace.
  always_ff @(posedge i_clk) begin
    if (mem_we && !i_rst) mem_q[mem_waddr] <= mem_wdata;
  end

  assign o_spi_miso = miso_q;
  assign o_busy     = busy_q;
  assign o_wel      = wel_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_responder
// Purpose  : Self-checking bench for spi_flash_responder. Drives SPI mode-0
//            transactions and compares results against an array/timestamp
//            model of the flash.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;

  localparam int          ADDR_W = 8;
  localparam int          PROG   = 500;
  localparam int          DEPTH  = 256;
  localparam logic [23:0] JID    = 24'hEF4018;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sclk = 1'b0;
  logic cs   = 1'b1;
  logic mosi = 1'b0;
  logic miso, busy_o, wel_o;

  spi_flash_responder #(
    .ADDR_W      (ADDR_W),
    .PROG_CYCLES (PROG),
    .JEDEC_ID    (JID)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_spi_clk  (sclk),
    .i_spi_cs   (cs),
    .i_spi_mosi (mosi),
    .o_spi_miso (miso),
    .o_busy     (busy_o),
    .o_wel      (wel_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    repeat (120000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1);
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Flash model: byte array, WEL flag and the cycle at which BUSY ends.
  logic [7:0] mem_m [DEPTH];
  bit         wel_m;
  bit         wel_clr;
  int         busy_end;
  int         sample_cyc;
  int         rise_cyc;
  logic [7:0] pdata [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    if (wel_clr && cyc >= busy_end) begin
      wel_m   = 1'b0;
      wel_clr = 1'b0;
    end
  endtask

  function automatic logic [7:0] exp_status(input int t);
    bit b, w;
    b = (t < busy_end);
    w = wel_m && !(wel_clr && t >= busy_end);
    return {6'b0, w, b};
  endfunction

  // Status is latched some tens of cycles before it is sampled; skip bytes
  // whose latch window straddles the BUSY end.
  function automatic bit ambiguous(input int t);
    return (busy_end >= t - 108) && (busy_end <= t + 8);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hFF;
    wel_m    = 1'b0;
    wel_clr  = 1'b0;
    busy_end = cyc + 256;
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(5);
  endtask

  task automatic cs_high();
    tick(5);
    cs = 1'b1;
    rise_cyc = cyc;
    tick(10);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      tick(5);
      if (i == 0) sample_cyc = cyc;
      rx[7-i] = miso;
      sclk = 1'b1;
      tick(5);
      sclk = 1'b0;
    end
  endtask

  task automatic send_addr(input logic [7:0] a);
    logic [7:0] rx;
    xfer(8'($urandom), 8, rx);
    xfer(8'($urandom), 8, rx);
    xfer(a, 8, rx);
  endtask

  task automatic do_cmd(input logic [7:0] op, input int nbits);
    logic [7:0] rx;
    settle();
    cs_low();
    xfer(op, 8, rx);
    if (nbits > 8) xfer(8'($urandom), nbits - 8, rx);
    cs_high();
    if (nbits == 8 && cyc >= busy_end) begin
      if (op == 8'h06) wel_m = 1'b1;
      if (op == 8'h04) wel_m = 1'b0;
    end
  endtask

  task automatic do_program(input logic [7:0] a, input int extra_bits);
    logic [7:0] rx, ad;
    bit ok;
    settle();
    ok = wel_m && (cyc >= busy_end);
    cs_low();
    xfer(8'h02, 8, rx);
    send_addr(a);
    for (int i = 0; i < pdata.size(); i++) begin
      xfer(pdata[i], 8, rx);
      ad = a + 8'(i);
      if (ok) begin
`ifdef SPI_RESP_NOR_AND_EN
        mem_m[ad] = mem_m[ad] & pdata[i];
`else
        mem_m[ad] = pdata[i];
`endif
      end
    end
    if (extra_bits > 0) xfer(8'h00, extra_bits, rx);
    cs_high();
    if (ok && pdata.size() > 0) begin
      busy_end = rise_cyc + 3 + PROG;
      wel_clr  = 1'b1;
    end
  endtask

  task automatic do_erase();
    logic [7:0] rx;
    settle();
    cs_low();
    xfer(8'h20, 8, rx);
    send_addr(8'($urandom));
    cs_high();
    if (wel_m && cyc >= busy_end) begin
      for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hFF;
      busy_end = rise_cyc + 3 + 256;
      wel_clr  = 1'b1;
    end
  endtask

  task automatic do_read(input logic [7:0] a, input int n, input string tag);
    logic [7:0] rx, ad;
    cs_low();
    xfer(8'h03, 8, rx);
    send_addr(a);
    for (int i = 0; i < n; i++) begin
      xfer(8'($urandom), 8, rx);
      ad = a + 8'(i);
      check(tag, {24'h0, rx}, {24'h0, mem_m[ad]});
    end
    cs_high();
  endtask

  task automatic read_id();
    logic [7:0] rx, ex;
    cs_low();
    xfer(8'h9F, 8, rx);
    for (int i = 0; i < 5; i++) begin
      xfer(8'h00, 8, rx);
      ex = (i < 3) ? JID[23-8*i -: 8] : 8'hFF;
      check("jedec", {24'h0, rx}, {24'h0, ex});
    end
    cs_high();
  endtask

  task automatic poll_status(input string tag, input int max_bytes);
    logic [7:0] rx;
    bit done;
    int t;
    done = 1'b0;
    cs_low();
    xfer(8'h05, 8, rx);
    for (int b = 0; b < max_bytes && !done; b++) begin
      xfer(8'h00, 8, rx);
      t = sample_cyc;
      if (!ambiguous(t)) check(tag, {24'h0, rx}, {24'h0, exp_status(t)});
      if (rx[0] == 1'b0 && t > busy_end + 8) done = 1'b1;
    end
    cs_high();
    check({tag, "_done"}, {31'h0, done}, 32'h1);
    settle();
  endtask

  initial begin
    logic [7:0] a;
    int n;

    // Reset state
    rst = 1'b1;
    tick(4);
    check("rst_miso", {31'h0, miso}, 32'h1);
    check("rst_busy", {31'h0, busy_o}, 32'h1);
    check("rst_wel", {31'h0, wel_o}, 32'h0);
    rst = 1'b0;
    model_reset();

    poll_status("stat_after_rst", 20);
    check("busy_pin_idle", {31'h0, busy_o}, 32'h0);
    read_id();

    // Write enable and program with wrap
    do_cmd(8'h06, 8);
    check("wel_after_wren", {31'h0, wel_o}, {31'h0, wel_m});
    poll_status("stat_wel", 4);
    pdata = '{8'hA5, 8'h5A, 8'h3C};
    do_program(8'hFE, 0);
    poll_status("stat_prog", 20);
    check("wel_after_prog", {31'h0, wel_o}, {31'h0, wel_m});
    do_read(8'hFD, 5, "rd_wrap");

    // Program without WEL: no effect
    pdata = '{8'h11, 8'h22};
    do_program(8'h10, 0);
    check("busy_no_wel", {31'h0, busy_o}, {31'h0, (cyc < busy_end)});
    check("wel_no_wel", {31'h0, wel_o}, 32'h0);
    do_read(8'h0F, 4, "rd_no_wel");

    // Second program over the same location (overwrite or AND)
    do_cmd(8'h06, 8);
    pdata = '{8'hF0};
    do_program(8'h40, 0);
    poll_status("stat_p1", 20);
    do_cmd(8'h06, 8);
    pdata = '{8'h3C};
    do_program(8'h40, 0);
    poll_status("stat_p2", 20);
    do_read(8'h40, 1, "rd_reprog");

    // Partial final byte discarded
    a = 8'($urandom_range(0, 255));
    do_cmd(8'h06, 8);
    pdata = '{8'($urandom), 8'($urandom)};
    do_program(a, 5);
    poll_status("stat_partial", 20);
    do_read(a, 3, "rd_partial");

    // WREN/WRDI need exactly 8 bits
    do_cmd(8'h06, 9);
    check("wren9_wel", {31'h0, wel_o}, {31'h0, wel_m});
    do_cmd(8'h06, 8);
    do_cmd(8'h04, 9);
    check("wrdi9_wel", {31'h0, wel_o}, {31'h0, wel_m});
    do_cmd(8'h04, 8);
    check("wrdi_wel", {31'h0, wel_o}, {31'h0, wel_m});

    // Randomized program/readback
    for (int it = 0; it < 6; it++) begin
      a = 8'($urandom_range(0, 255));
      n = $urandom_range(1, 5);
      pdata.delete();
      for (int k = 0; k < n; k++) pdata.push_back(8'($urandom));
      do_cmd(8'h06, 8);
      do_program(a, ($urandom_range(0, 1) == 1) ? 3 : 0);
      poll_status("stat_rand", 20);
      do_read(a - 8'd1, n + 2, "rd_rand");
    end

    // Sector erase
    do_cmd(8'h06, 8);
    do_erase();
    poll_status("stat_erase", 20);
    check("wel_after_erase", {31'h0, wel_o}, {31'h0, wel_m});
    do_read(8'($urandom_range(0, 255)), 24, "rd_erase");

    // Dirty some bytes, then reset in the middle of a program
    do_cmd(8'h06, 8);
    pdata = '{8'h12, 8'h34};
    do_program(8'h80, 0);
    poll_status("stat_pre_rst", 20);
    do_cmd(8'h06, 8);
    begin
      logic [7:0] rx;
      cs_low();
      xfer(8'h02, 8, rx);
      send_addr(8'h81);
      xfer(8'h00, 8, rx);
      xfer(8'h00, 4, rx);
    end
    rst = 1'b1;
    tick(3);
    cs   = 1'b1;
    sclk = 1'b0;
    tick(2);
    check("rst2_busy", {31'h0, busy_o}, 32'h1);
    rst = 1'b0;
    model_reset();
    poll_status("stat_rst2", 20);
    check("wel_rst2", {31'h0, wel_o}, 32'h0);
    do_read(8'h7F, 4, "rd_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
